// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the unified memory-port arbiter.
//   mem_arb_state_t         - arbiter FSM states (also exported on the debug port)
//   SRC_IF / SRC_D          - requester IDs used to name the arbitration winner
//   DEFAULT_MAX_DATA_STREAK - default data-grant streak limit in fair mode
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_IF   = 2'd1,
    ST_WAIT_D    = 2'd2,
    ST_WAIT_DROP = 2'd3
  } mem_arb_state_t;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_D  = 1'b1;

  localparam int DEFAULT_MAX_DATA_STREAK = 4;

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// mem_arb_streak_ctr: counts consecutive data grants issued while the IF
// requester was waiting, and raises force_if once the streak limit is hit so
// the next arbitration goes to IF. Used only when MEM_ARB_FAIR_EN is defined.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   idle      - arbiter is in IDLE this cycle
//   if_req    - IF request level
//   if_grant  - IF handshake this cycle (clears the streak)
//   d_grant   - data handshake this cycle
//   force_if  - streak limit reached; IF must win the next arbitration
// MAX_DATA_STREAK must lie in 1..15 (4-bit counter).
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req,
  input  logic if_grant,
  input  logic d_grant,
  output logic force_if
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DATA_STREAK);

  logic [3:0] cnt;

  // An IDLE cycle with no IF request means IF is not being starved, so the
  // streak restarts. The counter saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (if_grant) begin
      cnt <= 4'd0;
    end else if (idle && !if_req) begin
      cnt <= 4'd0;
    end else if (d_grant && if_req && (cnt != MAX_CNT)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign force_if = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single unified memory port between the
// instruction-fetch (IF) requester and the load/store (data) requester, with
// at most one transaction outstanding. Responses are routed back to the
// requester that issued them; a fetch flushed while in flight has its
// response silently dropped.
//
// Ports:
//   clk, rst                           - clock, synchronous active-high reset
//   if_req/if_addr/if_gnt              - IF request channel
//   if_rvalid/if_rdata                 - IF response (0-latency from mem_rvalid)
//   if_flush                           - discard any in-flight fetch
//   d_req/d_we/d_be/d_addr/d_wdata     - data request channel
//   d_gnt, d_rvalid/d_rdata            - data grant and response
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata, mem_gnt - slave request channel
//   mem_rvalid/mem_rdata               - slave response
//   state                              - debug view of the arbiter FSM
//
// Handshake: a request is accepted in the cycle where mem_req and mem_gnt are
// both high; requesters hold req/addr/wdata stable until granted. The slave
// answers with a single mem_rvalid pulse at least one cycle after the grant.
//
// Configuration: define MEM_ARB_FAIR_EN to cap consecutive data grants while
// IF waits at MAX_DATA_STREAK; otherwise data has strict priority and IF can
// starve under continuous data traffic.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              if_flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output mem_arb_state_t    state
);

  logic idle;
  logic winner;
  logic force_if;

`ifdef MEM_ARB_FAIR_EN
  mem_arb_streak_ctr #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .idle     (idle),
    .if_req   (if_req),
    .if_grant (if_gnt),
    .d_grant  (d_gnt),
    .force_if (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // Arbitration, request muxing and response routing. Outputs are held at 0
  // while rst is high so the port is quiet during reset.
  always_comb begin
    idle = (state == ST_IDLE) && !rst;

    // Data normally wins: it belongs to the older instruction.
    winner = SRC_D;
    if (force_if && if_req) begin
      winner = SRC_IF;
    end else if (d_req) begin
      winner = SRC_D;
    end else if (if_req) begin
      winner = SRC_IF;
    end

    mem_req   = idle && (if_req || d_req);
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (winner == SRC_D) begin
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        // Fetches read a full word.
        mem_be   = 4'hF;
        mem_addr = if_addr;
      end
    end

    if_gnt = mem_req && mem_gnt && (winner == SRC_IF);
    d_gnt  = mem_req && mem_gnt && (winner == SRC_D);

    // A flush coinciding with the response drops it.
    if_rvalid = !rst && (state == ST_WAIT_IF) && mem_rvalid && !if_flush;
    d_rvalid  = !rst && (state == ST_WAIT_D) && mem_rvalid;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          // mem_rvalid in IDLE (including in a grant cycle) is ignored.
          if (mem_req && mem_gnt) begin
            if (winner == SRC_D) begin
              state <= ST_WAIT_D;
            end else if (if_flush) begin
              state <= ST_WAIT_DROP;
            end else begin
              state <= ST_WAIT_IF;
            end
          end
        end
        ST_WAIT_IF: begin
          if (mem_rvalid) begin
            state <= ST_IDLE;
          end else if (if_flush) begin
            state <= ST_WAIT_DROP;
          end
        end
        ST_WAIT_D, ST_WAIT_DROP: begin
          if (mem_rvalid) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The slave must not answer in the cycle it grants.
  a_no_rvalid_in_grant: assert property (@(posedge clk) disable iff (rst)
    !(mem_req && mem_gnt && mem_rvalid));

  a_streak_range: assert property (@(posedge clk)
    (MAX_DATA_STREAK >= 1) && (MAX_DATA_STREAK <= 15));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. A behavioural
// slave grants immediately and answers after slave_lat cycles; expected
// responses are queued by the stimulus and popped by a negedge monitor.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_flush;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  mem_arb_state_t state;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  int   slave_lat = 1;
  logic rst_s = 1'b0;
  logic hs_s = 1'b0;
  logic [31:0] hs_addr = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_flush(if_flush),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- slave model ----------------
  assign mem_gnt = mem_req;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    case (a)
      32'h0000_0040: slave_data = 32'h0050_0093;
      32'h0000_0044: slave_data = 32'h00A0_0113;
      32'h0000_0100: slave_data = 32'hCAFE_F00D;
      default:       slave_data = {16'hDEAD, a[15:0]};
    endcase
  endfunction

  always @(negedge clk) begin
    rst_s   <= rst;
    hs_s    <= mem_req && mem_gnt;
    hs_addr <= mem_addr;
  end

  initial begin : slave
    int cnt;
    bit pend;
    logic [31:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    cnt = 0;
    pend = 1'b0;
    a = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_s) begin
        pend = 1'b0;
        mem_rvalid = 1'b0;
      end else if (mem_rvalid) begin
        pend = 1'b0;
        mem_rvalid = 1'b0;
      end else if (hs_s) begin
        pend = 1'b1;
        a = hs_addr;
        cnt = slave_lat - 1;
        mem_rvalid = (cnt == 0);
      end else if (pend) begin
        cnt--;
        mem_rvalid = (cnt == 0);
      end
      mem_rdata = mem_rvalid ? slave_data(a) : '0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_resp(input logic src, input logic [31:0] data);
    logic [32:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL resp_unexpected actual=%0h required=none (t=%0t)", {src, data}, $time);
    end else begin
      e = exp_q.pop_front();
      if ({src, data} !== e) begin
        failures++;
        $display("FAIL resp actual=%0h required=%0h (t=%0t)", {src, data}, e, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (if_rvalid) check_resp(SRC_IF, if_rdata);
    if (d_rvalid)  check_resp(SRC_D, d_rdata);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic src, input logic [31:0] data);
    exp_q.push_back({src, data});
  endtask

  task automatic check_quiet(input string name);
    chk(name, 64'(|{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                    mem_req, mem_we, mem_be, mem_addr, mem_wdata}), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int k;
    int cyc;
    int n_if;
    logic exp_if;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;

    // Reset state
    step(); step();
    sample();
    check_quiet("outs_in_reset");
    step(); rst = 1'b0;
    sample();
    check_quiet("outs_after_reset");
    chk("state_after_reset", 64'(state), 64'(ST_IDLE));

    // IF read
    step(); if_req = 1'b1; if_addr = 32'h40; slave_lat = 1;
    push_exp(SRC_IF, 32'h0050_0093);
    sample();
    chk("ifrd_if_gnt", 64'(if_gnt), 64'(1));
    chk("ifrd_mem_req", 64'(mem_req), 64'(1));
    chk("ifrd_mem_addr", 64'(mem_addr), 64'h40);
    chk("ifrd_mem_we", 64'(mem_we), 64'(0));
    step(); if_req = 1'b0;
    sample();
    chk("ifrd_rvalid", 64'(if_rvalid), 64'(1));
    chk("ifrd_gnt_low", 64'(if_gnt), 64'(0));
    chk("ifrd_state_wait", 64'(state), 64'(ST_WAIT_IF));
    step(); sample();
    chk("ifrd_state_idle", 64'(state), 64'(ST_IDLE));
    chk("ifrd_rvalid_low", 64'(if_rvalid), 64'(0));

    // Simultaneous IF and data load: data first
    step();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h44;
    push_exp(SRC_D, 32'hCAFE_F00D);
    push_exp(SRC_IF, 32'h00A0_0113);
    sample();
    chk("sim_d_gnt", 64'(d_gnt), 64'(1));
    chk("sim_if_gnt_low", 64'(if_gnt), 64'(0));
    chk("sim_mem_addr_d", 64'(mem_addr), 64'h100);
    step(); d_req = 1'b0;
    sample();
    chk("sim_d_rvalid", 64'(d_rvalid), 64'(1));
    chk("sim_no_gnt_in_resp", 64'(if_gnt), 64'(0));
    step(); sample();
    chk("sim_if_gnt", 64'(if_gnt), 64'(1));
    chk("sim_mem_addr_if", 64'(mem_addr), 64'h44);
    step(); if_req = 1'b0;
    sample();
    chk("sim_if_rvalid", 64'(if_rvalid), 64'(1));
    step();

    // Store
    step();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'h15B3;
    slave_lat = 2;
    push_exp(SRC_D, 32'hDEAD_0200);
    sample();
    chk("st_d_gnt", 64'(d_gnt), 64'(1));
    chk("st_mem_we", 64'(mem_we), 64'(1));
    chk("st_mem_wdata", 64'(mem_wdata), 64'h15B3);
    chk("st_mem_be", 64'(mem_be), 64'hF);
    chk("st_mem_addr", 64'(mem_addr), 64'h200);
    step(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    sample();
    chk("st_state_wait", 64'(state), 64'(ST_WAIT_D));
    chk("st_mem_idle_wdata", 64'(mem_wdata), 64'(0));
    step(); sample();
    chk("st_d_rvalid", 64'(d_rvalid), 64'(1));
    chk("st_if_rvalid_low", 64'(if_rvalid), 64'(0));
    step(); sample();
    chk("st_state_idle", 64'(state), 64'(ST_IDLE));

    // Flush one cycle after grant, response three cycles after grant
    step(); if_req = 1'b1; if_addr = 32'h48; slave_lat = 3;
    sample();
    chk("fl_if_gnt", 64'(if_gnt), 64'(1));
    step(); if_req = 1'b0; if_flush = 1'b1;
    sample();
    chk("fl_state_wait_if", 64'(state), 64'(ST_WAIT_IF));
    step(); if_flush = 1'b0;
    sample();
    chk("fl_state_drop", 64'(state), 64'(ST_WAIT_DROP));
    step(); sample();
    chk("fl_slave_resp", 64'(mem_rvalid), 64'(1));
    chk("fl_no_if_rvalid", 64'(if_rvalid), 64'(0));
    chk("fl_no_d_rvalid", 64'(d_rvalid), 64'(0));
    step(); sample();
    chk("fl_state_idle", 64'(state), 64'(ST_IDLE));

    // Flush in the grant cycle: request still issued, response dropped
    step(); if_req = 1'b1; if_addr = 32'h4C; if_flush = 1'b1; slave_lat = 1;
    sample();
    chk("flg_if_gnt", 64'(if_gnt), 64'(1));
    step(); if_req = 1'b0; if_flush = 1'b0;
    sample();
    chk("flg_state_drop", 64'(state), 64'(ST_WAIT_DROP));
    chk("flg_no_if_rvalid", 64'(if_rvalid), 64'(0));
    step(); sample();
    chk("flg_state_idle", 64'(state), 64'(ST_IDLE));

    // Flush coinciding with the response
    step(); if_req = 1'b1; if_addr = 32'h50; slave_lat = 1;
    sample();
    chk("flr_if_gnt", 64'(if_gnt), 64'(1));
    step(); if_req = 1'b0; if_flush = 1'b1;
    sample();
    chk("flr_no_if_rvalid", 64'(if_rvalid), 64'(0));
    chk("flr_if_rdata_zero", 64'(if_rdata), 64'(0));
    step(); if_flush = 1'b0;
    sample();
    chk("flr_state_idle", 64'(state), 64'(ST_IDLE));

    // Fairness / starvation: both requesters held for 50 transactions
    for (int i = 0; i < 50; i++) begin
      if (FAIR && (i % 5 == 4)) push_exp(SRC_IF, 32'hDEAD_0060);
      else                      push_exp(SRC_D, 32'hDEAD_0300);
    end
    step();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h60; slave_lat = 1;
    k = 0; cyc = 0; n_if = 0;
    while (k < 50 && cyc < 400) begin
      sample();
      cyc++;
      if (d_gnt || if_gnt) begin
        exp_if = FAIR && (k % 5 == 4);
        chk("fair_grant_src", 64'({if_gnt, d_gnt}), 64'({exp_if, !exp_if}));
        if (if_gnt) n_if++;
        k++;
        if (k == 50) begin
          step(); d_req = 1'b0; if_req = 1'b0;
        end
      end
    end
    chk("fair_total_grants", 64'(k), 64'(50));
    chk("fair_if_grants", 64'(n_if), FAIR ? 64'(10) : 64'(0));
    step(); step(); step(); sample();
    chk("fair_state_idle", 64'(state), 64'(ST_IDLE));

    // Reset in WAIT_D; slave is reset too and never answers
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; slave_lat = 3;
    sample();
    chk("rst_d_gnt", 64'(d_gnt), 64'(1));
    step(); d_req = 1'b0;
    sample();
    chk("rst_state_wait_d", 64'(state), 64'(ST_WAIT_D));
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    sample();
    check_quiet("rst_outs_zero");
    chk("rst_state_idle", 64'(state), 64'(ST_IDLE));
    step(); if_req = 1'b1; if_addr = 32'h40; slave_lat = 1;
    push_exp(SRC_IF, 32'h0050_0093);
    sample();
    chk("rst_fresh_if_gnt", 64'(if_gnt), 64'(1));
    step(); if_req = 1'b0;
    sample();
    chk("rst_fresh_if_rvalid", 64'(if_rvalid), 64'(1));
    step(); step(); sample();
    chk("end_state_idle", 64'(state), 64'(ST_IDLE));

    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single unified memory port between the instruction-fetch (IF) requester and the load/store (data) requester. It sits between the IF stage, the MEM stage and the memory slave inside `cpu_top`, and keeps at most one transaction outstanding. It routes each response back to the requester that issued it. If the IF stage is flushed by a taken branch or jump while its fetch is in flight, the arbiter silently drops that fetch's response.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MAX_DATA_STREAK`, 4: consecutive data grants allowed while IF is waiting (fair mode only); legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: IF read request.
- `if_addr` in `ADDR_W`: fetch address.
- `if_gnt` out 1: IF request accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out `DATA_W`: fetch data.
- `if_flush` in 1: discard any in-flight fetch.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store.
- `d_be` in 4: byte enables.
- `d_addr` in `ADDR_W`: data address.
- `d_wdata` in `DATA_W`: store data.
- `d_gnt` out 1: data request accepted.
- `d_rvalid` out 1: load data or store acknowledge.
- `d_rdata` out `DATA_W`: load data.
- `mem_req` out 1: request to the memory slave.
- `mem_we` out 1: write enable to the slave.
- `mem_be` out 4: byte enables to the slave.
- `mem_addr` out `ADDR_W`: address to the slave.
- `mem_wdata` out `DATA_W`: write data to the slave.
- `mem_gnt` in 1: slave accepted the request.
- `mem_rvalid` in 1: slave response valid.
- `mem_rdata` in `DATA_W`: slave response data.

## Operation

**States:** IDLE, WAIT_IF, WAIT_D, WAIT_DROP.

**IDLE:**
- Select a winner among asserted requests.
- `mem_*` outputs follow the winner combinationally.
- `mem_req` = the winner's request.
- The winner's grant = `mem_gnt`; the loser's grant = 0.

**Transitions out of IDLE on `mem_gnt`:**
- IF winner → WAIT_IF.
- Data winner → WAIT_D.
- If `if_flush` is asserted in the same cycle as an IF grant, the request is still issued and the next state is WAIT_DROP.

**Wait states:**
- `mem_req` = 0 and both grants = 0.
- On `mem_rvalid` → IDLE.
- WAIT_IF: pulse `if_rvalid` for one cycle with `if_rdata` = `mem_rdata`.
- WAIT_D: pulse `d_rvalid` for one cycle with `d_rdata` = `mem_rdata`.
- WAIT_DROP: no response is raised to either requester.

**Flush while waiting:** `if_flush` in WAIT_IF moves to WAIT_DROP. If it coincides with `mem_rvalid`, the response is dropped and the next state is IDLE.

**Default priority:** data wins over IF, because the data access belongs to the older instruction.

**Idle output values:**
- `mem_addr`/`mem_wdata`/`mem_be`/`mem_we` = 0 when no request.
- `if_rdata`/`d_rdata` = 0 when their valid is low.

**Stores:** a store completes only on `mem_rvalid` (write acknowledge); `d_rdata` is then don't-care but still driven from `mem_rdata`.

**Reset:**
- The arbiter returns to IDLE immediately and any outstanding response is forgotten.
- The slave is reset by the same `rst`.

## Timing
- Reset values: all outputs 0, state IDLE, streak counter 0.
- The request/grant handshake completes in the cycle where `*_req` and `mem_gnt` are both high. Requesters hold `req`/`addr`/`wdata` stable until granted.
- The slave asserts `mem_rvalid` at least 1 cycle after `mem_gnt`. A response in the grant cycle is illegal; it is ignored and flagged by an assertion.
- Minimum transaction cost is 2 cycles (grant, then response); a new request is not accepted in a response cycle.
- Response latency to the requester is 0: `*_rvalid` is `mem_rvalid` gated by state.
- `mem_rvalid` while in IDLE is ignored.

## Configuration
- **`MEM_ARB_FAIR_EN` defined:**
  - A 4-bit streak counter counts consecutive data grants issued while `if_req` was high.
  - When the count reaches `MAX_DATA_STREAK`, IF wins the next arbitration even if `d_req` is high.
  - Any IF grant clears the counter, as does an IDLE cycle with `if_req` low.
  - The counter saturates at `MAX_DATA_STREAK`.
- **`MEM_ARB_FAIR_EN` undefined:**
  - Strict data priority; the counter logic is absent.
  - IF may starve under continuous data traffic.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum `mem_arb_state_t`;
  - source IDs `SRC_IF`/`SRC_D`;
  - the default `MAX_DATA_STREAK`.
- One sub-module, `mem_arb_streak_ctr`, is instantiated only under `MEM_ARB_FAIR_EN`:
  - inputs: grant events and `if_req`;
  - output: `force_if`.
- The FSM, muxing and response routing live in the top module.

## Test plan
- **IF read:** `if_req`=1 at `0x00000040`, slave grants immediately and responds 1 cycle later with `0x00500093` → `if_gnt`=1 for 1 cycle, then `if_rvalid`=1 with `if_rdata`=`0x00500093`, then back to IDLE.
- **Simultaneous requests:** `if_req` and `d_req` (load `0x00000100`) asserted together → `d_gnt` first and `if_gnt` 0; after the `d_rvalid` response the IF request is granted.
- **Store:** `d_we`=1, `d_be`=`4'b1111`, `d_wdata`=`0x000015B3` to `0x00000200` → `mem_we`=1 and `mem_wdata`=`0x000015B3`; `d_rvalid` pulses on the ack; `if_rvalid` never pulses.
- **Flush in flight:** IF granted, `if_flush` asserted 1 cycle later, slave responds after 3 cycles → no `if_rvalid`; the arbiter reaches IDLE on that response.
- **Fairness (`MEM_ARB_FAIR_EN`, `MAX_DATA_STREAK`=4):** `d_req` held high and `if_req` held high → exactly 4 data grants, then 1 IF grant, with the pattern repeating; with the macro undefined, 0 IF grants over 50 transactions.
- **Reset mid-transaction:** `rst` asserted in WAIT_D, and the slave (reset by the same `rst`) never responds → next cycle all outputs 0 and state IDLE; a fresh `if_req` is granted normally.
